lab3_coin_collector: RTL and testbench
======================================

// Module: lab3_coin_collector
// PURPOSE
//  Upstream front end of the study-hall seat booking stage.
//  - Accumulates coin inserts into a 5-bit credit and latches the user's area/plug choice.
//  - Issues one booking request; only on reqValid cycles may the booking stage act (CLK enable).
//  - Captures the booking result and returns the change or the full refund as a one-cycle payout.
// PARAMETERS
//  MAX_CREDIT      31   highest credit accepted; must be <= 31 (money is 5 bits)
//  TIMEOUT_CYCLES  64   idle cycles in COLLECT before the block auto-refunds
//  COIN_A          5    value of coinValue 2'b01
//  COIN_B          10   value of coinValue 2'b10
//  COIN_C          20   value of coinValue 2'b11 (2'b00 = slug, always rejected)
// PORTS
//  CLK              in   1  rising-edge clock
//  RST_N            in   1  asynchronous active-low reset
//  coinValid        in   1  coin present this cycle
//  coinValue        in   2  coin code, see PARAMETERS
//  selValid         in   1  area selection strobe
//  selArea          in   2  00 loud, 01 quiet, 11 individual, 10 invalid
//  selPlug          in   1  plug seat wanted
//  cancel           in   1  user abort
//  seatReadyIn      in   1  booking stage seatReady
//  moneyLeftIn      in   6  booking stage moneyLeft
//  money            out  5  credit presented to booking stage
//  selectedArea     out  2  latched area
//  plugAvailability out  1  latched plug request
//  reqValid         out  1  one-cycle booking request
//  coinRejected     out  1  one-cycle pulse: coin refused
//  selRejected      out  1  one-cycle pulse: selArea 10 refused
//  refundValid      out  1  one-cycle payout strobe
//  refundAmount     out  6  payout value, valid with refundValid
//  bookedOk         out  1  one-cycle pulse with refundValid when seat was booked
//  busy             out  1  high in REQUEST, WAIT, REFUND
// BEHAVIOUR
//  Reset (async, RST_N=0): state IDLE; credit, timer and all outputs 0.
//  Mid-operation reset discards credit with no payout.
//  States: IDLE -> COLLECT -> REQUEST -> WAIT -> REFUND -> IDLE. money always equals credit.
//  IDLE:
//   - Valid coin loads credit and goes to COLLECT.
//   - selValid and cancel are ignored.
//  COLLECT:
//   - Priority: cancel > selValid > coin.
//   - cancel -> REFUND, refundAmount=credit.
//   - selValid with area != 10 latches area and plug -> REQUEST.
//   - selValid with area 10 pulses selRejected and stays in COLLECT.
//   - A coin in the same cycle as cancel or an accepted selValid is rejected.
//  Coin accept rule:
//   - Accepted only if credit+value <= MAX_CREDIT; add in 6 bits, compare, then store 5 bits.
//   - Otherwise pulse coinRejected; credit unchanged.
//   - A slug, or any coin in REQUEST, WAIT or REFUND, pulses coinRejected.
//  Timer:
//   - Clears on entry to COLLECT and on every accepted coin.
//   - At TIMEOUT_CYCLES-1 with no event -> REFUND with refundAmount=credit.
//  REQUEST:
//   - reqValid=1 for exactly one cycle; money, selectedArea and plugAvailability are held stable.
//   - Next state WAIT.
//  WAIT:
//   - One cycle; the booking stage's registered outputs are now valid.
//   - Capture refundAmount=moneyLeftIn and bookedOk_next=seatReadyIn -> REFUND.
//  REFUND:
//   - refundValid=1 and bookedOk asserted, one cycle.
//   - Next cycle: credit cleared, latched selection cleared, state IDLE.
//  Pulse outputs are registered and high for one cycle only; other outputs hold until changed.
// TESTING
//  1. Reset mid-COLLECT (credit 15), release -> IDLE, money=0, refundValid never asserts.
//  2. Coins 10,20; select 11 -> reqValid 1 cycle, money=30; seatReadyIn=1, moneyLeftIn=0
//     -> refundValid, refundAmount=0, bookedOk=1.
//  3. Coins 20,10,5 -> third coin rejected (35>31), money stays 30.
//     Then cancel -> refundAmount=30, bookedOk=0.
//  4. Coin 5, select 00; seatReadyIn=0, moneyLeftIn=5 -> refundAmount=5, bookedOk=0.
//  5. Coin 10 then no events for 64 cycles -> refundValid with refundAmount=10; next cycle IDLE.
//  6. Same cycle: cancel, selValid and coin 5 at credit 10 -> coinRejected=1, refund 10;
//     selArea=10 -> selRejected only.

Source files
------------

// File: rtl/lab3_coin_collector.sv
// Coin collector front end for the seat booking stage: gathers credit, latches the
// seat choice, issues one booking request and pays out change or a full refund.
module lab3_coin_collector #(
  parameter int MAX_CREDIT     = 31,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COIN_A         = 5,
  parameter int COIN_B         = 10,
  parameter int COIN_C         = 20
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       coinValid,
  input  logic [1:0] coinValue,
  input  logic       selValid,
  input  logic [1:0] selArea,
  input  logic       selPlug,
  input  logic       cancel,
  input  logic       seatReadyIn,
  input  logic [5:0] moneyLeftIn,
  output logic [4:0] money,
  output logic [1:0] selectedArea,
  output logic       plugAvailability,
  output logic       reqValid,
  output logic       coinRejected,
  output logic       selRejected,
  output logic       refundValid,
  output logic [5:0] refundAmount,
  output logic       bookedOk,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0] MAX6 = 6'(MAX_CREDIT);

  typedef enum logic [2:0] {
    IDLE, COLLECT, REQUEST, WAIT, REFUND
  } state_t;

  state_t state_reg, state_next;
  logic [4:0]    credit_reg, credit_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [1:0]    area_reg, area_next;
  logic          plug_reg, plug_next;
  logic [5:0]    refund_amount_reg, refund_amount_next;
  logic          req_valid_reg, req_valid_next;
  logic          coin_rej_reg, coin_rej_next;
  logic          sel_rej_reg, sel_rej_next;
  logic          refund_valid_reg, refund_valid_next;
  logic          booked_reg, booked_next;
  logic          busy_reg, busy_next;

  logic [5:0] coin_val;
  logic [5:0] coin_sum;
  logic       coin_fits;

  always_comb begin
    coin_val = 6'd0;
    case (coinValue)
      2'b01:   coin_val = 6'(COIN_A);
      2'b10:   coin_val = 6'(COIN_B);
      2'b11:   coin_val = 6'(COIN_C);
      default: coin_val = 6'd0;
    endcase
  end

  // Sum in 6 bits so an overflow past 31 is still visible to the compare.
  assign coin_sum  = {1'b0, credit_reg} + coin_val;
  assign coin_fits = (coinValue != 2'b00) && (coin_sum <= MAX6);

  always_comb begin
    state_next         = state_reg;
    credit_next        = credit_reg;
    timer_next         = timer_reg;
    area_next          = area_reg;
    plug_next          = plug_reg;
    refund_amount_next = refund_amount_reg;
    req_valid_next     = 1'b0;
    coin_rej_next      = 1'b0;
    sel_rej_next       = 1'b0;
    refund_valid_next  = 1'b0;
    booked_next        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (coinValid) begin
          if (coin_fits) begin
            credit_next = coin_sum[4:0];
            timer_next  = '0;
            state_next  = COLLECT;
          end else begin
            coin_rej_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_next         = REFUND;
          refund_amount_next = {1'b0, credit_reg};
          refund_valid_next  = 1'b1;
          coin_rej_next      = coinValid;
        end else if (selValid && (selArea != 2'b10)) begin
          area_next      = selArea;
          plug_next      = selPlug;
          state_next     = REQUEST;
          req_valid_next = 1'b1;
          coin_rej_next  = coinValid;
        end else begin
          sel_rej_next = selValid;
          if (coinValid && coin_fits) begin
            credit_next = coin_sum[4:0];
            timer_next  = '0;
          end else begin
            coin_rej_next = coinValid;
            // Saturate at the last count so an event there defers the timeout by one idle cycle.
            if (timer_reg == TIMER_LAST) begin
              if (!coinValid && !selValid) begin
                state_next         = REFUND;
                refund_amount_next = {1'b0, credit_reg};
                refund_valid_next  = 1'b1;
              end
            end else begin
              timer_next = timer_reg + 1'b1;
            end
          end
        end
      end
      REQUEST: begin
        coin_rej_next = coinValid;
        state_next    = WAIT;
      end
      WAIT: begin
        coin_rej_next      = coinValid;
        refund_amount_next = moneyLeftIn;
        booked_next        = seatReadyIn;
        refund_valid_next  = 1'b1;
        state_next         = REFUND;
      end
      REFUND: begin
        coin_rej_next = coinValid;
        credit_next   = 5'd0;
        area_next     = 2'b00;
        plug_next     = 1'b0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == REQUEST) || (state_next == WAIT) || (state_next == REFUND);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg         <= IDLE;
      credit_reg        <= 5'd0;
      timer_reg         <= '0;
      area_reg          <= 2'b00;
      plug_reg          <= 1'b0;
      refund_amount_reg <= 6'd0;
      req_valid_reg     <= 1'b0;
      coin_rej_reg      <= 1'b0;
      sel_rej_reg       <= 1'b0;
      refund_valid_reg  <= 1'b0;
      booked_reg        <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      credit_reg        <= credit_next;
      timer_reg         <= timer_next;
      area_reg          <= area_next;
      plug_reg          <= plug_next;
      refund_amount_reg <= refund_amount_next;
      req_valid_reg     <= req_valid_next;
      coin_rej_reg      <= coin_rej_next;
      sel_rej_reg       <= sel_rej_next;
      refund_valid_reg  <= refund_valid_next;
      booked_reg        <= booked_next;
      busy_reg          <= busy_next;
    end
  end

  assign money            = credit_reg;
  assign selectedArea     = area_reg;
  assign plugAvailability = plug_reg;
  assign reqValid         = req_valid_reg;
  assign coinRejected     = coin_rej_reg;
  assign selRejected      = sel_rej_reg;
  assign refundValid      = refund_valid_reg;
  assign refundAmount     = refund_amount_reg;
  assign bookedOk         = booked_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_lab3_coin_collector.sv
// Scoreboard bench for lab3_coin_collector: expected requests and payouts are queued
// as stimulus is driven and popped by a monitor when the DUT strobes them.
module tb_lab3_coin_collector;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       coinValid = 1'b0;
  logic [1:0] coinValue = 2'b00;
  logic       selValid = 1'b0;
  logic [1:0] selArea = 2'b00;
  logic       selPlug = 1'b0;
  logic       cancel = 1'b0;
  logic       seatReadyIn = 1'b0;
  logic [5:0] moneyLeftIn = 6'd0;
  logic [4:0] money;
  logic [1:0] selectedArea;
  logic       plugAvailability;
  logic       reqValid;
  logic       coinRejected;
  logic       selRejected;
  logic       refundValid;
  logic [5:0] refundAmount;
  logic       bookedOk;
  logic       busy;

  lab3_coin_collector dut (
    .CLK(CLK), .RST_N(RST_N),
    .coinValid(coinValid), .coinValue(coinValue),
    .selValid(selValid), .selArea(selArea), .selPlug(selPlug),
    .cancel(cancel), .seatReadyIn(seatReadyIn), .moneyLeftIn(moneyLeftIn),
    .money(money), .selectedArea(selectedArea), .plugAvailability(plugAvailability),
    .reqValid(reqValid), .coinRejected(coinRejected), .selRejected(selRejected),
    .refundValid(refundValid), .refundAmount(refundAmount), .bookedOk(bookedOk),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // {booked, amount} and {plug, area, money}
  logic [6:0] payout_q[$];
  logic [7:0] req_q[$];
  logic       req_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (reqValid) begin
        check_eq("req_one_cycle", {31'd0, req_prev}, 32'd0);
        if (req_q.size() == 0) check_eq("req_unexpected", 32'd1, 32'd0);
        else begin
          logic [7:0] r;
          r = req_q.pop_front();
          $display("request: money=%0d area=%0d plug=%0d", money, selectedArea, plugAvailability);
          check_eq("req_money", {27'd0, money}, {27'd0, r[4:0]});
          check_eq("req_area", {30'd0, selectedArea}, {30'd0, r[6:5]});
          check_eq("req_plug", {31'd0, plugAvailability}, {31'd0, r[7]});
        end
      end
      if (refundValid) begin
        if (payout_q.size() == 0) check_eq("payout_unexpected", 32'd1, 32'd0);
        else begin
          logic [6:0] p;
          p = payout_q.pop_front();
          $display("payout: amount=%0d booked=%0d", refundAmount, bookedOk);
          check_eq("payout_amount", {26'd0, refundAmount}, {26'd0, p[5:0]});
          check_eq("payout_booked", {31'd0, bookedOk}, {31'd0, p[6]});
        end
      end else if (bookedOk) begin
        check_eq("booked_without_refund", {31'd0, bookedOk}, 32'd0);
      end
      req_prev <= reqValid;
    end else begin
      req_prev <= 1'b0;
    end
  end

  function automatic int coin_val(input logic [1:0] code);
    case (code)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction

  int model_credit = 0;

  task automatic insert_coin(input logic [1:0] code);
    int v;
    logic exp_rej;
    v = coin_val(code);
    exp_rej = (code == 2'b00) || (model_credit + v > 31);
    if (!exp_rej) model_credit += v;
    coinValid = 1'b1;
    coinValue = code;
    @(negedge CLK);
    coinValid = 1'b0;
    $display("coin code=%0d money=%0d rejected=%0d", code, money, coinRejected);
    check_eq("coin_rejected", {31'd0, coinRejected}, {31'd0, exp_rej});
    check_eq("coin_money", {27'd0, money}, model_credit);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && payout_q.size() != 0; i++) @(negedge CLK);
    check_eq("payout_drained", payout_q.size(), 32'd0);
    @(negedge CLK);
    model_credit = 0;
    check_eq("idle_money", {27'd0, money}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge CLK);
    check_eq("rst_money", {27'd0, money}, 32'd0);
    check_eq("rst_refund", {31'd0, refundValid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Slug in IDLE is refused
    insert_coin(2'b00);
    check_eq("slug_busy", {31'd0, busy}, 32'd0);

    // 1: reset mid-COLLECT discards credit without payout
    insert_coin(2'b10);
    insert_coin(2'b01);
    #2 RST_N = 1'b0;
    #1 check_eq("async_rst_money", {27'd0, money}, 32'd0);
    model_credit = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    check_eq("post_rst_money", {27'd0, money}, 32'd0);
    check_eq("post_rst_refund", {31'd0, refundValid}, 32'd0);

    // 2: 10 + 20, individual seat with plug, booked with no change
    insert_coin(2'b10);
    insert_coin(2'b11);
    seatReadyIn = 1'b1;
    moneyLeftIn = 6'd0;
    req_q.push_back({1'b1, 2'b11, 5'd30});
    payout_q.push_back({1'b1, 6'd0});
    selValid = 1'b1; selArea = 2'b11; selPlug = 1'b1;
    @(negedge CLK);
    selValid = 1'b0; selPlug = 1'b0;
    check_eq("req_busy", {31'd0, busy}, 32'd1);
    wait_drain();
    check_eq("req_queue_empty", req_q.size(), 32'd0);

    // 3: overflow coin refused, then cancel refunds 30
    insert_coin(2'b11);
    insert_coin(2'b10);
    insert_coin(2'b01);
    payout_q.push_back({1'b0, 6'd30});
    cancel = 1'b1;
    @(negedge CLK);
    cancel = 1'b0;
    wait_drain();

    // 4: loud area, not booked, 5 returned
    insert_coin(2'b01);
    seatReadyIn = 1'b0;
    moneyLeftIn = 6'd5;
    req_q.push_back({1'b0, 2'b00, 5'd5});
    payout_q.push_back({1'b0, 6'd5});
    selValid = 1'b1; selArea = 2'b00; selPlug = 1'b0;
    @(negedge CLK);
    selValid = 1'b0;
    wait_drain();

    // 5: inactivity timeout after 64 idle cycles
    insert_coin(2'b10);
    payout_q.push_back({1'b0, 6'd10});
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      cnt++;
      if (refundValid) break;
    end
    check_eq("timeout_cycles", cnt, 32'd64);
    @(negedge CLK);
    model_credit = 0;
    check_eq("timeout_idle_money", {27'd0, money}, 32'd0);
    check_eq("timeout_idle_busy", {31'd0, busy}, 32'd0);

    // 6: cancel beats selValid and coin in the same cycle
    insert_coin(2'b10);
    payout_q.push_back({1'b0, 6'd10});
    cancel = 1'b1; selValid = 1'b1; selArea = 2'b11; coinValid = 1'b1; coinValue = 2'b01;
    @(negedge CLK);
    cancel = 1'b0; selValid = 1'b0; coinValid = 1'b0;
    check_eq("tie_coin_rej", {31'd0, coinRejected}, 32'd1);
    check_eq("tie_sel_rej", {31'd0, selRejected}, 32'd0);
    wait_drain();

    // 6b: invalid area only pulses selRejected
    insert_coin(2'b10);
    selValid = 1'b1; selArea = 2'b10;
    @(negedge CLK);
    selValid = 1'b0;
    check_eq("bad_area_sel_rej", {31'd0, selRejected}, 32'd1);
    check_eq("bad_area_coin_rej", {31'd0, coinRejected}, 32'd0);
    check_eq("bad_area_busy", {31'd0, busy}, 32'd0);
    check_eq("bad_area_money", {27'd0, money}, 32'd10);
    @(negedge CLK);
    check_eq("sel_rej_pulse", {31'd0, selRejected}, 32'd0);
    payout_q.push_back({1'b0, 6'd10});
    cancel = 1'b1;
    @(negedge CLK);
    cancel = 1'b0;
    wait_drain();
    check_eq("final_req_queue", req_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
